// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Pure declarations: no latency, no flow control.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    typedef logic [15:0] bcd_time_t;

    localparam int        BASE_DEC = 10;
    localparam int        BASE_SEX = 6;
    localparam bcd_time_t BCD_ZERO = 16'h0000;
    // The only time that reaches zero on the next decrement.
    localparam bcd_time_t BCD_ONE  = 16'h0001;

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle between a timer controller and countdown_timer.
// Level signals sampled every clock; no handshake or backpressure.
interface countdown_timer_if;
    import countdown_timer_pkg::*;

    logic      load;
    bcd_time_t load_value;
    logic      start;
    logic      stop;
    bcd_time_t value;
    logic      running;
    logic      done;
    logic      expired;

    modport master (
        output load, load_value, start, stop,
        input  value, running, done, expired
    );

    modport slave (
        input  load, load_value, start, stop,
        output value, running, done, expired
    );

endinterface

// File: rtl/countdown_timer_bcd_digit_down.sv
// One down-counting BCD digit with saturating load and borrow-out.
// Registered digit, updates the edge after dec/load; never stalls.
module bcd_digit_down
    import countdown_timer_pkg::*;
#(
    parameter int BASE = BASE_DEC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       borrow
);

    localparam logic [3:0] MAX_DIGIT = 4'(BASE - 1);

    logic [3:0] dout_q;
    logic [3:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        if (load) begin
            dout_d = (din > MAX_DIGIT) ? MAX_DIGIT : din;
        end else if (dec) begin
            dout_d = (dout_q == 4'd0) ? MAX_DIGIT : dout_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= 4'd0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout   = dout_q;
    assign borrow = dec && (dout_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: prescaled 1-per-TICK_DIV decrement, pause/resume, expiry.
// Inputs take effect on the outputs one edge after sampling; no backpressure.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    countdown_timer_if.slave  bus
);

    localparam int            PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] CNT_LAST = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          tick;
    logic          is_zero;
    bcd_time_t     value;
    logic [3:0]    borrow;

    assign is_zero = (value == BCD_ZERO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tick    = 1'b0;
        if (bus.load) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (bus.start && !bus.stop && !is_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Stop freezes the prescaler so a resume finishes the same period.
                    if (bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        tick  = !is_zero;
                        if (value == BCD_ONE) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    bcd_digit_down #(.BASE(BASE_DEC)) u_sec_units (
        .clk    (clk),
        .rst    (rst),
        .dec    (tick),
        .load   (bus.load),
        .din    (bus.load_value[3:0]),
        .dout   (value[3:0]),
        .borrow (borrow[0])
    );

    bcd_digit_down #(.BASE(BASE_SEX)) u_sec_tens (
        .clk    (clk),
        .rst    (rst),
        .dec    (borrow[0]),
        .load   (bus.load),
        .din    (bus.load_value[7:4]),
        .dout   (value[7:4]),
        .borrow (borrow[1])
    );

    bcd_digit_down #(.BASE(BASE_DEC)) u_min_units (
        .clk    (clk),
        .rst    (rst),
        .dec    (borrow[1]),
        .load   (bus.load),
        .din    (bus.load_value[11:8]),
        .dout   (value[11:8]),
        .borrow (borrow[2])
    );

    // Min-tens borrow-out can only fire from 0000, which is never decremented.
    bcd_digit_down #(.BASE(BASE_DEC)) u_min_tens (
        .clk    (clk),
        .rst    (rst),
        .dec    (borrow[2]),
        .load   (bus.load),
        .din    (bus.load_value[15:12]),
        .dout   (value[15:12]),
        .borrow (borrow[3])
    );

    assign bus.value   = value;
    assign bus.running = (state_q == ST_RUN);
    assign bus.expired = (state_q == ST_EXPIRED);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios followed by random
// stimulus, checked against a seconds-based reference model.
module tb_countdown_timer;

    localparam int TD     = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAUS = 2;
    localparam int S_EXP  = 3;

    typedef struct packed {
        logic [15:0] value;
        logic        running;
        logic        done;
        logic        expired;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_if ifc ();

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (ifc)
    );

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    // Reference model: remaining time held as plain seconds.
    int m_secs  = 0;
    int m_state = S_IDLE;
    int m_phase = 0;
    bit m_done  = 1'b0;

    function automatic int clamp(input logic [3:0] d, input int mx);
        return (int'(d) > mx) ? mx : int'(d);
    endfunction

    function automatic int sat_secs(input logic [15:0] lv);
        int mt, mu, st, su;
        mt = clamp(lv[15:12], 9);
        mu = clamp(lv[11:8], 9);
        st = clamp(lv[7:4], 5);
        su = clamp(lv[3:0], 9);
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit ld, input logic [15:0] lv,
                        input bit st, input bit sp);
        obs_t e;
        @(negedge clk);
        rst_n          = r;
        ifc.load       = ld;
        ifc.load_value = lv;
        ifc.start      = st;
        ifc.stop       = sp;
        @(posedge clk);
        m_done = 1'b0;
        if (!r) begin
            m_secs  = 0;
            m_state = S_IDLE;
            m_phase = 0;
        end else if (ld) begin
            m_secs  = sat_secs(lv);
            m_state = S_IDLE;
            m_phase = 0;
        end else begin
            case (m_state)
                S_IDLE, S_PAUS: begin
                    if (st && !sp && m_secs != 0) m_state = S_RUN;
                end
                S_RUN: begin
                    if (sp) begin
                        m_state = S_PAUS;
                    end else begin
                        m_phase++;
                        if (m_phase == TD) begin
                            m_phase = 0;
                            m_secs--;
                            if (m_secs == 0) begin
                                m_state = S_EXP;
                                m_done  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        e.value   = to_bcd(m_secs);
        e.running = (m_state == S_RUN);
        e.done    = m_done;
        e.expired = (m_state == S_EXP);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] lv);
        step(1'b1, 1'b1, lv, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a fresh set of registered outputs.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scoreboard", {13'b0, ifc.value, ifc.running, ifc.done, ifc.expired},
                    {13'b0, e});
            end
        end
    end

    initial begin
        bit          r, ld, st, sp;
        logic [15:0] lv;
        ifc.load       = 1'b0;
        ifc.load_value = 16'h0000;
        ifc.start      = 1'b0;
        ifc.stop       = 1'b0;

        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        #1 chk("reset_outputs", {13'b0, ifc.value, ifc.running, ifc.done, ifc.expired}, 32'h0);

        do_load(16'h1000);
        #1 chk("load_1000", {16'b0, ifc.value}, 32'h1000);
        do_start();
        #1 chk("start_running", {31'b0, ifc.running}, 32'h1);
        repeat (3) idle();
        #1 chk("no_early_dec", {16'b0, ifc.value}, 32'h1000);
        idle();
        #1 chk("ripple_0959", {16'b0, ifc.value}, 32'h0959);
        repeat (4) idle();
        #1 chk("ripple_0958", {16'b0, ifc.value}, 32'h0958);

        do_load(16'h0002);
        do_start();
        repeat (4) idle();
        #1 chk("expiry_0001", {16'b0, ifc.value}, 32'h0001);
        repeat (4) idle();
        #1 chk("expiry_zero_done", {14'b0, ifc.value, ifc.done, ifc.expired}, 32'h3);
        idle();
        #1 chk("done_one_cycle", {30'b0, ifc.done, ifc.expired}, 32'h1);
        do_start();
        #1 chk("start_in_expired", {14'b0, ifc.value, ifc.running, ifc.expired}, 32'h1);

        do_load(16'h0010);
        do_start();
        idle();
        idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        #1 chk("stop_pauses", {31'b0, ifc.running}, 32'h0);
        repeat (10) idle();
        #1 chk("pause_hold", {15'b0, ifc.value, ifc.running}, 32'h20);
        do_start();
        idle();
        #1 chk("resume_not_early", {16'b0, ifc.value}, 32'h0010);
        idle();
        #1 chk("resume_0009", {16'b0, ifc.value}, 32'h0009);

        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        #1 chk("start_stop_pauses", {31'b0, ifc.running}, 32'h0);

        do_load(16'h0040);
        do_start();
        repeat (3) idle();
        do_load(16'h0030);
        #1 chk("load_beats_tick", {15'b0, ifc.value, ifc.running}, 32'h60);
        repeat (4) idle();
        #1 chk("idle_after_load", {16'b0, ifc.value}, 32'h0030);

        do_load(16'h0000);
        do_start();
        #1 chk("start_at_zero", {30'b0, ifc.running, ifc.expired}, 32'h0);

        do_load(16'hAB7C);
        #1 chk("load_saturate", {16'b0, ifc.value}, 32'h9959);
        do_start();
        idle();
        idle();
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        #1 chk("reset_in_run", {13'b0, ifc.value, ifc.running, ifc.done, ifc.expired}, 32'h0);
        idle();
        #1 chk("no_done_after_reset", {29'b0, ifc.running, ifc.done, ifc.expired}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) != 0);
            ld = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0)
                lv = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            else
                lv = 16'($urandom);
            step(r, ld, lv, st, sp);
        end

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
